// File: rtl/barret_1279_rr_sched.sv
// barret_1279_rr_sched
// Round-robin arbiter in front of a shared 2-stage Barrett reduction
// pipeline (q = 1279). Each 21-bit operand comes back as a canonical
// 11-bit residue, tagged with the index of the requester that sent it.
module barret_1279_rr_sched #(
  parameter int NREQ = 4,
  parameter int TAGW = 2,
  parameter int Q    = 1279,
  parameter int MU   = 3279
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*21-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [10:0]          out_data,
  output logic [TAGW-1:0]      out_tag,
  output logic                 busy,
  output logic [15:0]          op_count
);

  localparam logic [21:0] MU22 = 22'(MU);
  localparam logic [21:0] Q22  = 22'(Q);
  localparam logic [12:0] Q13  = 13'(Q);

  // Barrett reduction of a 21-bit operand. The estimate t never exceeds
  // floor(a/q) and falls short of it by at most 2, so two conditional
  // subtractions are enough to make the result canonical.
  function automatic logic [10:0] barrett_reduce(input logic [20:0] a);
    logic [9:0]  q1;
    logic [21:0] prod;
    logic [10:0] t;
    logic [21:0] tq;
    logic [21:0] diff;
    logic [12:0] r;
    q1   = a[20:11];
    prod = {12'd0, q1} * MU22;
    t    = 11'(prod >> 11);
    tq   = {11'd0, t} * Q22;
    diff = {1'b0, a} - tq;
    r    = 13'(diff);
    if (r >= Q13) begin
      r = r - Q13;
    end else begin
      r = r;
    end
    if (r >= Q13) begin
      r = r - Q13;
    end else begin
      r = r;
    end
    return r[10:0];
  endfunction

  // Pipeline and arbiter state
  logic              s1_valid_q, s1_valid_d;
  logic [20:0]       s1_data_q,  s1_data_d;
  logic [TAGW-1:0]   s1_tag_q,   s1_tag_d;
  logic              s2_valid_q, s2_valid_d;
  logic [10:0]       s2_data_q,  s2_data_d;
  logic [TAGW-1:0]   s2_tag_q,   s2_tag_d;
  logic [TAGW-1:0]   ptr_q,      ptr_d;
  logic [15:0]       op_count_q, op_count_d;

  // Combinational control
  logic              s2_adv_s;
  logic              s1_adv_s;
  logic              gnt_found_s;
  logic [TAGW-1:0]   gnt_idx_s;
  logic              accept_s;
  logic [20:0]       sel_data_s;
  int                dist_s;
  int                best_dist_s;

  // Round-robin search: pick the valid requester closest to the pointer
  // (distance measured upward modulo NREQ) and mux its operand.
  always_comb begin
    s2_adv_s    = !s2_valid_q || out_ready;
    s1_adv_s    = !s1_valid_q || s2_adv_s;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    dist_s      = 0;
    best_dist_s = NREQ;
    sel_data_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (i >= int'(ptr_q)) begin
        dist_s = i - int'(ptr_q);
      end else begin
        dist_s = i + NREQ - int'(ptr_q);
      end
      if (req_valid[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        gnt_found_s = 1'b1;
        gnt_idx_s   = TAGW'(i);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_s == TAGW'(i)) begin
        sel_data_s = req_data[21*i +: 21];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
    accept_s = s1_adv_s && gnt_found_s && !rst;
    if (accept_s) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state for the pipeline stages, the pointer and the result counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    ptr_d      = ptr_q;
    op_count_d = op_count_q;
    if (s1_adv_s) begin
      s1_valid_d = accept_s;
      if (accept_s) begin
        s1_data_d = sel_data_s;
        s1_tag_d  = gnt_idx_s;
      end else begin
        s1_data_d = s1_data_q;
        s1_tag_d  = s1_tag_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = barrett_reduce(s1_data_q);
        s2_tag_d  = s1_tag_q;
      end else begin
        s2_data_d = s2_data_q;
        s2_tag_d  = s2_tag_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
    if (accept_s) begin
      if (gnt_idx_s == TAGW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + TAGW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
    if (s2_valid_q && out_ready) begin
      op_count_d = op_count_q + 16'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  // State registers with synchronous reset; reset drops in-flight operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 21'd0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= 11'd0;
      s2_tag_q   <= '0;
      ptr_q      <= '0;
      op_count_q <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      ptr_q      <= ptr_d;
      op_count_q <= op_count_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_tag   = s2_tag_q;
  assign busy      = s1_valid_q || s2_valid_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/barret_1279_rr_sched.md
Name: barret_1279_rr_sched

Overview:
- Shares one Barrett modular-reduction datapath (q = 1279) among NREQ requesters.
- A round-robin arbiter picks one request per cycle. The operand passes through a 2-stage registered reduction pipeline with valid/ready backpressure.
- Each result is returned with the requester index as a tag.
- Sits between NTT/polynomial-arithmetic producers, which emit 21-bit products, and consumers of canonical 11-bit residues.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAGW, 2, tag width; must equal ceil(log2(NREQ)).
- Q, 1279, modulus; fixed for this block and not intended to be overridden.
- MU, 3279, Barrett constant floor(2^22/Q).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  NREQ*21  packed operands; requester i at bits [21*i+20 : 21*i].
- req_ready  out  NREQ  one-hot or zero; requester i's operand is accepted this cycle when req_valid[i] && req_ready[i].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  11  a mod 1279, always < 1279.
- out_tag  out  TAGW  index of the requester that supplied the operand.
- busy  out  1  high while any pipeline stage holds data.
- op_count  out  16  number of results delivered (out_valid && out_ready); wraps 65535 -> 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, req_ready=0, busy=0, op_count=0.
  - Round-robin pointer set to 0, so requester 0 has highest priority.
  - Pipeline stage valids cleared. out_data and out_tag are set to 0.
  - Reset asserted mid-operation discards all in-flight operands; no result for them is ever produced.
- Pipeline: S1 (operand register) -> S2 (result register, drives out_*).
  - S2 advances (load or drain) when !S2.valid || out_ready.
  - S1 advances when !S1.valid || S2 advances.
  - accept_en = S1 advances.
- Arbitration (combinational, same cycle):
  - If accept_en, grant the first i with req_valid[i]=1, searching from pointer p upward modulo NREQ.
  - Drive req_ready[i]=1 for that i only.
  - req_ready is 0 for all requesters when accept_en=0 or no request is valid.
  - On acceptance, p <- granted index + 1 (mod NREQ). Otherwise p holds.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Latency and throughput:
  - Operand accepted at edge N appears with out_valid=1 after edge N+1, i.e. 2 cycles accept-to-result.
  - Full throughput is 1 result per cycle when out_ready stays high.
- Stall: while out_valid && !out_ready, out_data and out_tag hold stable.
  - S1 may still load once if empty, then req_ready drops to 0.
  - No operand is lost or duplicated.
- Ordering: results leave in acceptance order; there is no reordering.
- Arithmetic (computed between S1 and S2, from S1 contents):
  - q1 = a >> 11.
  - t = (q1 * 3279) >> 11, with the product held at >= 22 bits and never truncated to 21 bits.
  - r = a - t*1279, with r held at >= 13 bits.
  - Subtract 1279 up to two times while r >= 1279.
  - Result must equal a mod 1279 for every a in 0..2^21-1. Worst case a=2^21-1 needs two subtractions.
- busy = S1.valid || S2.valid.
- op_count increments by 1 on each output handshake and wraps modulo 2^16.
- Simultaneous events: an output handshake and a new acceptance in the same cycle are both honoured; the pipeline shifts without a bubble.

Test Plan:
- Reset then idle -> out_valid=0, req_ready=0, busy=0, op_count=0 across 10 cycles.
- Requester 2 sends a=1635841 (1279^2), out_ready=1 -> after 2 cycles out_data=0, out_tag=2, op_count=1.
- Requester 0 sends a=2097151 (2^21-1) -> out_data=870. Requester 1 sends a=1278 -> out_data=1278. Requester 3 sends a=1279 -> out_data=0.
- All 4 req_valid held high with distinct operands, out_ready=1 -> grants in order 0,1,2,3,0,... with one result per cycle after 2-cycle fill; each out_tag matches its operand.
- Backpressure:
  - Setup: all requesters valid, out_ready=0 for 5 cycles.
  - During stall: two operands accepted, then req_ready=0 and out_data held stable.
  - After out_ready=1: results drain in order with no loss.
- Reset asserted with S1 and S2 full -> next cycle out_valid=0, busy=0, op_count=0. The next grant goes to requester 0; no stale result emerges.
